fwd_hazard_unit: RTL and testbench
==================================

# fwd_hazard_unit

Parametrised forwarding and hazard unit for the 5-stage pipeline, driving the EX-stage operand muxes and the IF/ID stall / ID/EX bubble controls.
- Resolves forwarding per source operand independently, for NUM_SRC operands, with EX/MEM priority over MEM/WB and register 0 never forwarded.
- Detects load-use hazards and tracks one outstanding multi-cycle multiply with a countdown scoreboard, so that dependent or structurally conflicting instructions are held in decode.

## Interface
Parameters:
- REG_BITS, 5, register-index width (matches `REGISTER_BITS).
- NUM_SRC, 2, number of source operands per instruction (1..4).
- MUL_LAT, 4, multiply latency in cycles from issue to MEM/WB writeback (2..15).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_ex_src  in  NUM_SRC*REG_BITS  EX-stage source indices; operand i at [i*REG_BITS +: REG_BITS].
- if_id_src  in  NUM_SRC*REG_BITS  decode-stage source indices, same packing.
- if_id_mul  in  1  decode-stage instruction is a multiply.
- id_ex_rd, id_ex_memread  in  REG_BITS, 1  EX-stage destination and load flag.
- ex_mem_rd, ex_mem_regwrite  in  REG_BITS, 1  EX/MEM destination and write enable.
- mem_wb_rd, mem_wb_regwrite  in  REG_BITS, 1  MEM/WB destination and write enable.
- mul_issue, mul_rd  in  1, REG_BITS  multiply entering EX this cycle, and its destination.
- src_mux  out  2*NUM_SRC  operand i select at [2i+1:2i]: 00 regfile, 01 EX/MEM, 10 MEM/WB; 11 never driven.
- stall  out  1  hold PC and IF/ID.
- flush_id_ex  out  1  insert bubble into ID/EX.
- mul_busy  out  1  multiply outstanding.
- stall_cnt  out  16  stall-cycle count (see Configuration).

## Operation
Forwarding (combinational, per operand i, with s = id_ex_src[i]):
- 01 if ex_mem_regwrite && ex_mem_rd != 0 && ex_mem_rd == s.
- Else 10 if mem_wb_regwrite && mem_wb_rd != 0 && mem_wb_rd == s.
- Else 00.
- Each operand is evaluated independently; both operands may select the same stage.

Load-use (combinational):
- lu = id_ex_memread && id_ex_rd != 0 && any if_id_src[i] == id_ex_rd.

Multiply scoreboard FSM, states IDLE and BUSY; registers cnt[3:0] and pend_rd:
- IDLE: on mul_issue, go to BUSY with cnt <= MUL_LAT-1 and pend_rd <= mul_rd.
- BUSY: cnt decrements each cycle. When cnt == 1: with mul_issue, reload (cnt <= MUL_LAT-1, pend_rd <= mul_rd, stay BUSY); without mul_issue, go to IDLE.
- BUSY with mul_issue and cnt > 1 is a protocol violation. The unit ignores it; this cannot occur while stall is honoured.
- mh = BUSY && pend_rd != 0 && any if_id_src[i] == pend_rd, for i < NUM_SRC.
- sh = BUSY && cnt > 1 && if_id_mul.
- stall = flush_id_ex = lu | mh | sh.
- mul_busy = (state == BUSY).

## Timing
- src_mux, stall and flush_id_ex are combinational from inputs and current state: zero latency, valid in the same cycle.
- Load-use stall lasts exactly 1 cycle when the pipeline honours it.
- Data-dependence stall on a multiply result releases in the cycle after the multiply's last BUSY cycle. The result then forwards from MEM/WB.
- Structural multiply stall: back-to-back multiplies issue MUL_LAT-1 cycles apart.
- Reset (asserted asynchronously, at any time including mid-multiply):
  - state IDLE, cnt 0, pend_rd 0, stall_cnt 0.
  - Outputs: mul_busy 0. stall, flush_id_ex and src_mux depend only on inputs.
  - A multiply in flight at reset is forgotten.

## Configuration
- FWD_STALL_CNT_EN defined: stall_cnt is a 16-bit register that increments on every clock edge with stall == 1. It saturates at 16'hFFFF and is cleared by rst.
- FWD_STALL_CNT_EN undefined: stall_cnt tied to 16'h0000 and no counter flops are instantiated.

## Test plan
- EX/MEM and MEM/WB both write r3, operand0 = r3, operand1 = r3 -> src_mux = 4'b0101. Change to operand1 = r7 -> 4'b0001.
- ex_mem_rd = 0 with regwrite = 1, operand0 = r0 -> src_mux[1:0] = 00.
- id_ex_memread = 1, id_ex_rd = r5, if_id_src[1] = r5 -> stall = flush_id_ex = 1 for that cycle; 0 the next cycle after the load advances.
- MUL_LAT = 4: mul_issue with mul_rd = r9 at cycle 0, if_id_src[0] = r9 held -> mul_busy 1 for cycles 1-3 and stall 1 for cycles 1-3; stall 0 at cycle 4.
- MUL_LAT = 4: if_id_mul = 1 while busy -> stall while cnt = 3, 2; drops at cnt = 1. mul_issue in that cycle reloads cnt = 3 and mul_busy stays 1.
- Assert rst mid-BUSY (cnt = 2) -> mul_busy 0 immediately and stall 0. With FWD_STALL_CNT_EN, stall_cnt = 0 after 3 prior stall cycles had read 3.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// Forwarding / hazard unit: per-operand EX forwarding selects, load-use and
// multiply-scoreboard stalls. Optional stall counter under FWD_STALL_CNT_EN.

module fwd_src_lane #(
  parameter int REG_BITS = 5
) (
  input  logic [REG_BITS-1:0] ex_src,
  input  logic [REG_BITS-1:0] dec_src,
  input  logic [REG_BITS-1:0] ex_mem_rd,
  input  logic                ex_mem_regwrite,
  input  logic [REG_BITS-1:0] mem_wb_rd,
  input  logic                mem_wb_regwrite,
  input  logic [REG_BITS-1:0] id_ex_rd,
  input  logic                id_ex_memread,
  input  logic                busy,
  input  logic [REG_BITS-1:0] pend_rd,
  output logic [1:0]          sel,
  output logic                lu_hit,
  output logic                mh_hit
);
  // EX/MEM holds the younger result, so it wins over MEM/WB
  always_comb begin
    sel = 2'b00;
    if (ex_mem_regwrite && ex_mem_rd != '0 && ex_mem_rd == ex_src)
      sel = 2'b01;
    else if (mem_wb_regwrite && mem_wb_rd != '0 && mem_wb_rd == ex_src)
      sel = 2'b10;
  end

  assign lu_hit = id_ex_memread && id_ex_rd != '0 && dec_src == id_ex_rd;
  assign mh_hit = busy && pend_rd != '0 && dec_src == pend_rd;
endmodule

module fwd_hazard_unit #(
  parameter int REG_BITS = 5,
  parameter int NUM_SRC  = 2,
  parameter int MUL_LAT  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_SRC*REG_BITS-1:0]  id_ex_src,
  input  logic [NUM_SRC*REG_BITS-1:0]  if_id_src,
  input  logic                         if_id_mul,
  input  logic [REG_BITS-1:0]          id_ex_rd,
  input  logic                         id_ex_memread,
  input  logic [REG_BITS-1:0]          ex_mem_rd,
  input  logic                         ex_mem_regwrite,
  input  logic [REG_BITS-1:0]          mem_wb_rd,
  input  logic                         mem_wb_regwrite,
  input  logic                         mul_issue,
  input  logic [REG_BITS-1:0]          mul_rd,
  output logic [2*NUM_SRC-1:0]         src_mux,
  output logic                         stall,
  output logic                         flush_id_ex,
  output logic                         mul_busy,
  output logic [15:0]                  stall_cnt
);
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] RELOAD = 4'(MUL_LAT - 1);

  state_t              state, state_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic [REG_BITS-1:0] pend_rd, pend_nxt;
  logic [NUM_SRC-1:0]  lu_hit, mh_hit;
  logic                lu, mh, sh;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
    fwd_src_lane #(.REG_BITS(REG_BITS)) u_lane (
      .ex_src          (id_ex_src[i*REG_BITS +: REG_BITS]),
      .dec_src         (if_id_src[i*REG_BITS +: REG_BITS]),
      .ex_mem_rd       (ex_mem_rd),
      .ex_mem_regwrite (ex_mem_regwrite),
      .mem_wb_rd       (mem_wb_rd),
      .mem_wb_regwrite (mem_wb_regwrite),
      .id_ex_rd        (id_ex_rd),
      .id_ex_memread   (id_ex_memread),
      .busy            (state == BUSY),
      .pend_rd         (pend_rd),
      .sel             (src_mux[2*i +: 2]),
      .lu_hit          (lu_hit[i]),
      .mh_hit          (mh_hit[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pend_rd <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pend_rd <= pend_nxt;
    end
  end

  // A mul_issue while BUSY with cnt > 1 is a protocol violation and is ignored
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pend_nxt  = pend_rd;
    case (state)
      IDLE: if (mul_issue) begin
        state_nxt = BUSY;
        cnt_nxt   = RELOAD;
        pend_nxt  = mul_rd;
      end
      BUSY: begin
        if (cnt == 4'd1) begin
          if (mul_issue) begin
            cnt_nxt  = RELOAD;
            pend_nxt = mul_rd;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mul_busy    = (state == BUSY);
    lu          = |lu_hit;
    mh          = |mh_hit;
    sh          = (state == BUSY) && (cnt > 4'd1) && if_id_mul;
    stall       = lu | mh | sh;
    flush_id_ex = stall;
  end

`ifdef FWD_STALL_CNT_EN
  logic [15:0] stall_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt_q <= '0;
    else if (stall && stall_cnt_q != 16'hFFFF)
      stall_cnt_q <= stall_cnt_q + 16'd1;
  end
  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit (REG_BITS=5, NUM_SRC=2, MUL_LAT=4).
module tb_fwd_hazard_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  id_ex_src, if_id_src;
  logic        if_id_mul;
  logic [4:0]  id_ex_rd, ex_mem_rd, mem_wb_rd, mul_rd;
  logic        id_ex_memread, ex_mem_regwrite, mem_wb_regwrite, mul_issue;
  logic [3:0]  src_mux;
  logic        stall, flush_id_ex, mul_busy;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  int sc     = 0;   // stall edges seen by the counter, tracked from the stimulus

  fwd_hazard_unit #(.REG_BITS(5), .NUM_SRC(2), .MUL_LAT(4)) dut (
    .clk(clk), .rst(rst), .id_ex_src(id_ex_src), .if_id_src(if_id_src),
    .if_id_mul(if_id_mul), .id_ex_rd(id_ex_rd), .id_ex_memread(id_ex_memread),
    .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite),
    .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite),
    .mul_issue(mul_issue), .mul_rd(mul_rd), .src_mux(src_mux), .stall(stall),
    .flush_id_ex(flush_id_ex), .mul_busy(mul_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_sc(input int n);
`ifdef FWD_STALL_CNT_EN
    return 32'(n);
`else
    return 32'(n * 0);
`endif
  endfunction

  initial begin
    rst = 1'b1;
    id_ex_src = '0; if_id_src = '0; if_id_mul = 0;
    id_ex_rd = 0; id_ex_memread = 0; ex_mem_rd = 0; ex_mem_regwrite = 0;
    mem_wb_rd = 0; mem_wb_regwrite = 0; mul_issue = 0; mul_rd = 0;
    tick(); tick();
    chk("rst_busy", 32'(mul_busy), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_mux", 32'(src_mux), 0);
    chk("rst_cnt", 32'(stall_cnt), 0);
    rst = 1'b0;

    // Forwarding
    ex_mem_rd = 3; ex_mem_regwrite = 1; mem_wb_rd = 3; mem_wb_regwrite = 1;
    id_ex_src = {5'd3, 5'd3}; #1;
    chk("fwd_both_exmem", 32'(src_mux), 4'b0101);
    id_ex_src = {5'd7, 5'd3}; #1;
    chk("fwd_op1_none", 32'(src_mux), 4'b0001);
    ex_mem_regwrite = 0; #1;
    chk("fwd_memwb_only", 32'(src_mux), 4'b0010);
    ex_mem_rd = 7; ex_mem_regwrite = 1; id_ex_src = {5'd3, 5'd7}; #1;
    chk("fwd_split", 32'(src_mux), 4'b1001);
    ex_mem_rd = 0; mem_wb_rd = 0; id_ex_src = {5'd0, 5'd0}; #1;
    chk("fwd_r0", 32'(src_mux), 4'b0000);
    ex_mem_rd = 4; ex_mem_regwrite = 0; mem_wb_rd = 4; mem_wb_regwrite = 0;
    id_ex_src = {5'd4, 5'd4}; #1;
    chk("fwd_no_we", 32'(src_mux), 4'b0000);
    id_ex_src = '0;

    // Load-use
    id_ex_memread = 1; id_ex_rd = 5; if_id_src = {5'd5, 5'd2}; #1;
    chk("lu_stall", 32'(stall), 1);
    chk("lu_flush", 32'(flush_id_ex), 1);
    tick(); sc++;
    id_ex_memread = 0; #1;
    chk("lu_release", 32'(stall), 0);
    id_ex_memread = 1; id_ex_rd = 0; if_id_src = {5'd0, 5'd0}; #1;
    chk("lu_r0", 32'(stall), 0);
    id_ex_memread = 0;

    // Multiply data dependence, issue at cycle 0
    mul_issue = 1; mul_rd = 9; if_id_src = {5'd1, 5'd9}; #1;
    chk("mul_c0_stall", 32'(stall), 0);
    tick(); mul_issue = 0; #1;
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("mul_c%0d_busy", c), 32'(mul_busy), 1);
      chk($sformatf("mul_c%0d_stall", c), 32'(stall), 1);
      tick(); sc++;
    end
    chk("mul_c4_busy", 32'(mul_busy), 0);
    chk("mul_c4_stall", 32'(stall), 0);
    chk("cnt_after_mul", 32'(stall_cnt), exp_sc(sc));

    // Structural multiply hazard and reload
    if_id_src = {5'd2, 5'd1}; mul_issue = 1; mul_rd = 10; if_id_mul = 1; #1;
    chk("sh_idle", 32'(stall), 0);
    tick(); mul_issue = 0; #1;
    chk("sh_cnt3", 32'(stall), 1);
    tick(); sc++;
    chk("sh_cnt2", 32'(stall), 1);
    tick(); sc++;
    chk("sh_cnt1", 32'(stall), 0);
    chk("sh_cnt1_busy", 32'(mul_busy), 1);
    mul_issue = 1; mul_rd = 11; tick(); mul_issue = 0; #1;
    chk("reload_busy", 32'(mul_busy), 1);
    chk("reload_stall", 32'(stall), 1);
    tick(); sc++;
    chk("mid_stall", 32'(stall), 1);
    chk("pre_rst_cnt", 32'(stall_cnt), exp_sc(sc));

    // Asynchronous reset mid-BUSY (cnt = 2)
    #2 rst = 1'b1; #1;
    chk("arst_busy", 32'(mul_busy), 0);
    chk("arst_stall", 32'(stall), 0);
    chk("arst_cnt", 32'(stall_cnt), 0);
    tick(); rst = 1'b0; tick();
    chk("post_rst_busy", 32'(mul_busy), 0);

    // pend_rd of zero never causes a dependence stall
    if_id_mul = 0; mul_issue = 1; mul_rd = 0; if_id_src = {5'd0, 5'd0};
    tick(); mul_issue = 0; #1;
    chk("mh_r0_busy", 32'(mul_busy), 1);
    chk("mh_r0_stall", 32'(stall), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
